// File: rtl/rf_dump_unit.sv
// Read-side debug walker: scans every register-file entry and streams it out over valid/ready.
// Define RF_DUMP_CHECKSUM_EN to append a modulo-2^DW checksum word after the last entry.
module rf_dump_unit #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

`ifdef RF_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, SUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

  state_t        state, state_nxt;
  logic [DW-1:0] data_q;
  logic [AW-1:0] idx_q;
  logic          at_last;
  logic          advance;

  assign at_last = (idx_q == LAST_IDX);
  assign advance = (state == SEND) && out_ready && !at_last;

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum_q <= '0;
    end else if (state == LOAD) begin
      sum_q <= rd;
    end else if (advance) begin
      sum_q <= wrap_add(sum_q, rd);
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture stage: ra is presented combinationally, the word lands here on the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (state == LOAD) begin
      data_q <= rd;
      idx_q  <= '0;
    end else if (advance) begin
      data_q <= rd;
      idx_q  <= idx_q + AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    ra        = '0;
    out_valid = 1'b0;
    out_data  = data_q;
    out_idx   = idx_q;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        ra        = at_last ? idx_q : idx_q + AW'(1);
`ifdef RF_DUMP_CHECKSUM_EN
        if (out_ready && at_last) state_nxt = SUM;
`else
        out_last  = at_last;
        if (out_ready && at_last) state_nxt = DONE;
`endif
      end
`ifdef RF_DUMP_CHECKSUM_EN
      SUM: begin
        out_valid = 1'b1;
        out_data  = sum_q;
        out_idx   = '0;
        out_last  = 1'b1;
        if (out_ready) state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_dump_unit.sv
// Directed bench for rf_dump_unit with a behavioural 8-entry register file on the read port.
// Checksum expectations follow RF_DUMP_CHECKSUM_EN when it is defined for the build.
module tb_rf_dump_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  ra;
  logic [31:0] rd;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [8];
  assign rd = rf[ra];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_dump_unit #(.NREG(8), .AW(3), .DW(32)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic [2:0]  i;
    logic        ra_chk;
    logic [2:0]  ra;
    logic        last;
    logic        dn;
    logic        bsy;
  } vec_t;

  vec_t tbl [16];
  int   ntbl;

  function automatic vec_t mk(input logic rdy, input logic v, input logic [31:0] d,
                              input logic [2:0] i, input logic ra_chk, input logic [2:0] rav,
                              input logic last, input logic dn, input logic bsy);
    vec_t r;
    r.rdy = rdy; r.v = v; r.d = d; r.i = i; r.ra_chk = ra_chk; r.ra = rav;
    r.last = last; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ident();
    for (int k = 0; k < 8; k++) rf[k] = 32'(k);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " valid"}, 32'(out_valid), 0);
    chk({nm, " data"},  out_data, 0);
    chk({nm, " idx"},   32'(out_idx), 0);
    chk({nm, " last"},  32'(out_last), 0);
    chk({nm, " busy"},  32'(busy), 0);
    chk({nm, " done"},  32'(done), 0);
    chk({nm, " ra"},    32'(ra), 0);
  endtask

  // One complete dump from IDLE with optional stall, mid-stall write and stray start.
  task automatic run_dump(input string nm, input logic [31:0] w [8], input int restart_at,
                          input int stall_idx, input int stall_n, input logic wr_en,
                          input int wr_addr, input logic [31:0] wr_data);
    logic [31:0] s;
    s = 32'h0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({nm, " load busy"}, 32'(busy), 1);
    chk({nm, " load valid"}, 32'(out_valid), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == stall_idx) begin
        for (int k = 0; k < stall_n; k++) begin
          out_ready = 1'b0;
          if (k == 0 && wr_en) rf[wr_addr] = wr_data;
          #1;
          chk({nm, " stall valid"}, 32'(out_valid), 1);
          chk({nm, " stall data"}, out_data, w[i]);
          chk({nm, " stall idx"}, 32'(out_idx), 32'(i));
          step();
        end
      end
      out_ready = 1'b1;
      start = (i == restart_at);
      #1;
      chk({nm, " valid"}, 32'(out_valid), 1);
      chk({nm, " data"}, out_data, w[i]);
      chk({nm, " idx"}, 32'(out_idx), 32'(i));
`ifdef RF_DUMP_CHECKSUM_EN
      chk({nm, " last"}, 32'(out_last), 0);
`else
      chk({nm, " last"}, 32'(out_last), (i == 7) ? 1 : 0);
`endif
      chk({nm, " done early"}, 32'(done), 0);
      s = s + w[i];
      step();
    end
    start = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
    chk({nm, " sum valid"}, 32'(out_valid), 1);
    chk({nm, " sum data"}, out_data, s);
    chk({nm, " sum idx"}, 32'(out_idx), 0);
    chk({nm, " sum last"}, 32'(out_last), 1);
    step();
`endif
    chk({nm, " done pulse"}, 32'(done), 1);
    chk({nm, " done valid"}, 32'(out_valid), 0);
    chk({nm, " done busy"}, 32'(busy), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      chk({nm, " post done"}, 32'(done), 0);
      chk({nm, " post busy"}, 32'(busy), 0);
      step();
    end
  endtask

  initial begin
    logic [31:0] w [8];
    logic ck;
`ifdef RF_DUMP_CHECKSUM_EN
    ck = 1'b1;
`else
    ck = 1'b0;
`endif
    fill_ident();

    // Reset state while n_rst is held low.
    #2;
    chk_reset_outputs("reset");
    step();
    step();
    n_rst = 1'b1;
    step();
    chk_reset_outputs("idle");

    // Basic dump of the identity file.
    for (int k = 0; k < 8; k++) w[k] = 32'(k);
    run_dump("basic", w, -1, -1, 0, 1'b0, 0, 32'h0);

    // Table: same dump with three stalled cycles at index 4.
    ntbl = 0;
    tbl[ntbl++] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 0, 0, 1, 1, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 1, 1, 1, 2, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 2, 2, 1, 3, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 3, 3, 1, 4, 0, 0, 1);
    tbl[ntbl++] = mk(0, 1, 4, 4, 1, 5, 0, 0, 1);
    tbl[ntbl++] = mk(0, 1, 4, 4, 1, 5, 0, 0, 1);
    tbl[ntbl++] = mk(0, 1, 4, 4, 1, 5, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 4, 4, 1, 5, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 5, 5, 1, 6, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 6, 6, 1, 7, 0, 0, 1);
    tbl[ntbl++] = mk(1, 1, 7, 7, 1, 7, !ck, 0, 1);
    if (ck) tbl[ntbl++] = mk(1, 1, 32'h1C, 0, 0, 0, 1, 0, 1);
    tbl[ntbl++] = mk(1, 0, 0, 0, 1, 0, 0, 1, 1);
    tbl[ntbl++] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[ntbl++] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);

    fill_ident();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < ntbl; r++) begin
      out_ready = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d valid", r), 32'(out_valid), 32'(tbl[r].v));
      if (tbl[r].v) begin
        chk($sformatf("tbl%0d data", r), out_data, tbl[r].d);
        chk($sformatf("tbl%0d idx", r), 32'(out_idx), 32'(tbl[r].i));
      end
      if (tbl[r].ra_chk) chk($sformatf("tbl%0d ra", r), 32'(ra), 32'(tbl[r].ra));
      chk($sformatf("tbl%0d last", r), 32'(out_last), 32'(tbl[r].last));
      chk($sformatf("tbl%0d done", r), 32'(done), 32'(tbl[r].dn));
      chk($sformatf("tbl%0d busy", r), 32'(busy), 32'(tbl[r].bsy));
      step();
    end

    // Carry out of bit 31 is discarded in the checksum.
    for (int k = 0; k < 8; k++) rf[k] = 32'h0;
    rf[0] = 32'hFFFF_FFFF;
    rf[1] = 32'h0000_0002;
    for (int k = 0; k < 8; k++) w[k] = rf[k];
    run_dump("carry", w, -1, -1, 0, 1'b0, 0, 32'h0);

    // Write to entry 6 while index 3 is stalled shows up in the dump.
    fill_ident();
    for (int k = 0; k < 8; k++) w[k] = 32'(k);
    w[6] = 32'hDEAD_BEEF;
    run_dump("livewr", w, -1, 3, 2, 1'b1, 6, 32'hDEAD_BEEF);

    // start pulsed during SEND is ignored and not queued.
    fill_ident();
    for (int k = 0; k < 8; k++) w[k] = 32'(k);
    run_dump("restart", w, 3, -1, 0, 1'b0, 0, 32'h0);

    // Reset at index 2 abandons the dump immediately.
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("pre-rst idx", 32'(out_idx), 2);
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("midrst no done", 32'(done), 0);
      chk("midrst idle", 32'(busy), 0);
      step();
    end
    run_dump("fresh", w, -1, -1, 0, 1'b0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
